imm_gen_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational immediate generator. Takes a raw instruction word plus a one-hot format select, extracts the immediate fields itself, and sign/zero-extends to XLEN. The result is registered into a 2-entry elastic buffer with valid/ready handshake on both sides. Sits between decode and the ID/EX register; a flush input lets branch/trap logic kill pending entries.

---
 rtl/imm_gen_pipe_pkg.sv | 26 ++
 rtl/imm_extract.sv | 58 +++++
 rtl/imm_gen_pipe.sv | 107 ++++++++++
 tb/tb_imm_gen_pipe.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// Shared widths and one-hot ext_ctrl codes for the immediate generator.
// Defining IMMGEN_RVC_EN widens ext_ctrl to 8 bits and adds CI/CJ.
package imm_gen_pipe_pkg;

  localparam int XLEN_DEF = 32;

`ifdef IMMGEN_RVC_EN
  localparam int EXT_CTRL_W = 8;
`else
  localparam int EXT_CTRL_W = 6;
`endif

  typedef logic [EXT_CTRL_W-1:0] ext_ctrl_t;

  localparam ext_ctrl_t EXT_CTRL_SHAMT = ext_ctrl_t'(1);
  localparam ext_ctrl_t EXT_CTRL_ITYPE = ext_ctrl_t'(2);
  localparam ext_ctrl_t EXT_CTRL_STYPE = ext_ctrl_t'(4);
  localparam ext_ctrl_t EXT_CTRL_UTYPE = ext_ctrl_t'(8);
  localparam ext_ctrl_t EXT_CTRL_BTYPE = ext_ctrl_t'(16);
  localparam ext_ctrl_t EXT_CTRL_JAL   = ext_ctrl_t'(32);
`ifdef IMMGEN_RVC_EN
  localparam ext_ctrl_t EXT_CTRL_CI    = ext_ctrl_t'(64);
  localparam ext_ctrl_t EXT_CTRL_CJ    = ext_ctrl_t'(128);
`endif

endpackage

// File: rtl/imm_extract.sv
// Combinational field extraction and extension of an instruction immediate.
// IMMGEN_RVC_EN enables the compressed CI and CJ formats.
module imm_extract
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [31:0]           instr,
  input  logic [EXT_CTRL_W-1:0] ext_ctrl,
  output logic [XLEN-1:0]       imm,
  output logic                  err
);

  always_comb begin
    imm = '0;
    err = 1'b0;
    case (ext_ctrl)
      EXT_CTRL_SHAMT:
        imm = (XLEN == 64) ? XLEN'(instr[25:20])
                           : XLEN'(instr[24:20]);
      EXT_CTRL_ITYPE:
        imm = XLEN'($signed(instr[31:20]));
      EXT_CTRL_STYPE:
        imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      EXT_CTRL_UTYPE:
        imm = XLEN'($signed({instr[31:12], 12'b0}));
      EXT_CTRL_BTYPE:
        imm = XLEN'($signed({instr[31], instr[7],
                             instr[30:25], instr[11:8],
                             1'b0}));
      EXT_CTRL_JAL:
        imm = XLEN'($signed({instr[31], instr[19:12],
                             instr[20], instr[30:21],
                             1'b0}));
`ifdef IMMGEN_RVC_EN
      EXT_CTRL_CI:
        imm = XLEN'($signed({instr[12], instr[6:2]}));
      EXT_CTRL_CJ:
        imm = XLEN'($signed({instr[12], instr[8],
                             instr[10:9], instr[6],
                             instr[7], instr[2],
                             instr[11], instr[5:3],
                             1'b0}));
`endif
      // zero-hot and multi-hot selects both land here
      default: err = 1'b1;
    endcase
  end

`ifdef IMMGEN_RVC_EN
  logic unused_bits;
  assign unused_bits = ^instr[1:0];
`else
  logic unused_bits;
  assign unused_bits = ^instr[6:0];
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with a 2-entry valid/ready elastic buffer.
// IMMGEN_RVC_EN (see package) selects the 8-bit ext_ctrl with CI/CJ.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = 5,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic [EXT_CTRL_W-1:0] ext_ctrl,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       imm,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  imm_err
);

  if (DEPTH != 2) begin : g_bad_depth
    $error("imm_gen_pipe: DEPTH must be 2");
  end
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0]  x_imm;
  logic             x_err;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr    (instr),
    .ext_ctrl (ext_ctrl),
    .imm      (x_imm),
    .err      (x_err)
  );

  logic [XLEN-1:0]  imm_q [2];
  logic [TAG_W-1:0] tag_q [2];
  logic [1:0]       err_q;
  logic             wp;
  logic             rp;
  logic [1:0]       cnt;
  logic [XLEN-1:0]  last_imm;
  logic [TAG_W-1:0] last_tag;
  logic             last_err;
  logic             push;
  logic             pop;

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // an empty buffer keeps presenting whatever was last shown
  always_comb begin
    imm     = last_imm;
    out_tag = last_tag;
    imm_err = last_err;
    if (out_valid) begin
      imm     = imm_q[rp];
      out_tag = tag_q[rp];
      imm_err = err_q[rp];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else if (flush) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      imm_q[wp] <= x_imm;
      tag_q[wp] <= in_tag;
      err_q[wp] <= x_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_imm <= '0;
      last_tag <= '0;
      last_err <= 1'b0;
    end else begin
      last_imm <= imm;
      last_tag <= out_tag;
      last_err <= imm_err;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: vector table, directed
// handshake corners, and a randomized run against a queue model.
module tb_imm_gen_pipe;
  import imm_gen_pipe_pkg::*;

  localparam int XL = 32;
  localparam int TW = 5;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic                  flush = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  out_ready = 1'b0;
  logic [31:0]           instr = '0;
  logic [EXT_CTRL_W-1:0] ext_ctrl = '0;
  logic [TW-1:0]         in_tag = '0;
  logic                  in_ready;
  logic                  out_valid;
  logic [XL-1:0]         imm;
  logic [TW-1:0]         out_tag;
  logic                  imm_err;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(XL), .TAG_W(TW), .DEPTH(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .ext_ctrl  (ext_ctrl),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm       (imm),
    .out_tag   (out_tag),
    .imm_err   (imm_err)
  );

  localparam logic [5:0] C_SH = 6'b000001;
  localparam logic [5:0] C_I  = 6'b000010;
  localparam logic [5:0] C_S  = 6'b000100;
  localparam logic [5:0] C_U  = 6'b001000;
  localparam logic [5:0] C_B  = 6'b010000;
  localparam logic [5:0] C_J  = 6'b100000;

  typedef struct {
    logic [31:0] w;
    logic [5:0]  c;
    logic [31:0] e;
    logic        er;
  } vec_t;

  typedef struct {
    logic [31:0]   imm;
    logic [TW-1:0] tag;
    logic          err;
  } ent_t;

  vec_t tv[13];
  ent_t q[$];
  ent_t last;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [31:0] w,
                     input logic [5:0] c, input logic [TW-1:0] t);
    in_valid = v;
    instr    = w;
    ext_ctrl = EXT_CTRL_W'(c);
    in_tag   = t;
  endtask

  // I-type word whose immediate equals the tag
  function automatic logic [31:0] iw(input logic [TW-1:0] t);
    return {7'b0, t, 20'h00093};
  endfunction

  // Offsets built arithmetically from the ISA field layout
  function automatic logic [32:0] ref_imm(input logic [31:0] w,
                                          input logic [5:0] c);
    int unsigned u;
    int s;
    int v;
    u = w;
    s = $signed(w);
    v = 0;
    if ($countones(c) != 1) return {1'b1, 32'h0};
    case (c)
      C_SH: v = int'((u / (1 << 20)) % 32);
      C_I:  v = s >>> 20;
      C_S:  v = (s >>> 25) * 32 + int'((u / 128) % 32);
      C_U:  v = int'(u - (u % 4096));
      C_B:  v = (w[31] ? -4096 : 0)
              + int'((u / 128) % 2) * 2048
              + int'((u / (1 << 25)) % 64) * 32
              + int'((u / 256) % 16) * 2;
      default: v = (w[31] ? -(1 << 20) : 0)
              + int'((u / 4096) % 256) * 4096
              + int'((u / (1 << 20)) % 2) * 2048
              + int'((u / (1 << 21)) % 1024) * 2;
    endcase
    return {1'b0, 32'(v)};
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{32'hFFF00093, C_I,  32'hFFFFFFFF, 1'b0};
    tv[1]  = '{32'hFE000EE3, C_B,  32'hFFFFFFFC, 1'b0};
    tv[2]  = '{32'h0080006F, C_J,  32'h00000008, 1'b0};
    tv[3]  = '{32'h12345037, C_U,  32'h12345000, 1'b0};
    tv[4]  = '{32'hFE112E23, C_S,  32'hFFFFFFFC, 1'b0};
    tv[5]  = '{32'h01F0D093, C_SH, 32'h0000001F, 1'b0};
    tv[6]  = '{32'hC0505013, C_SH, 32'h00000005, 1'b0};
    tv[7]  = '{32'h7FF00013, C_I,  32'h000007FF, 1'b0};
    tv[8]  = '{32'hFFDFF06F, C_J,  32'hFFFFFFFC, 1'b0};
    tv[9]  = '{32'hFFF00093, 6'b000011, 32'h0, 1'b1};
    tv[10] = '{32'hFFF00093, 6'b000000, 32'h0, 1'b1};
    tv[11] = '{32'h12345037, 6'b110000, 32'h0, 1'b1};
    tv[12] = '{32'h80000037, C_U,  32'h80000000, 1'b0};

    repeat (3) tick;
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_imm", imm, 32'h0);
    chk("rst_tag", out_tag, 5'h0);
    chk("rst_err", imm_err, 1'b0);
    chk("rst_ready", in_ready, 1'b1);

    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drv(1'b1, tv[i].w, tv[i].c, TW'(i));
      tick;
      drv(1'b0, 32'h0, 6'h0, '0);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_imm", i), imm, tv[i].e);
      chk($sformatf("vec%0d_err", i), imm_err, tv[i].er);
      chk($sformatf("vec%0d_tag", i), out_tag, TW'(i));
      tick;
    end

    // backpressure: tags 1..3 against a stalled consumer
    out_ready = 1'b0;
    drv(1'b1, iw(5'd1), C_I, 5'd1);
    tick;
    drv(1'b1, iw(5'd2), C_I, 5'd2);
    @(negedge clk);
    chk("bp_one_ready", in_ready, 1'b1);
    chk("bp_one_tag", out_tag, 5'd1);
    tick;
    drv(1'b1, iw(5'd3), C_I, 5'd3);
    @(negedge clk);
    chk("bp_full_ready", in_ready, 1'b0);
    tick;
    tick;
    @(negedge clk);
    chk("bp_hold_ready", in_ready, 1'b0);
    chk("bp_hold_tag", out_tag, 5'd1);
    chk("bp_hold_imm", imm, 32'd1);
    out_ready = 1'b1;
    tick;
    @(negedge clk);
    chk("full_pp_valid", out_valid, 1'b1);
    chk("full_pp_tag", out_tag, 5'd2);
    chk("full_pp_ready", in_ready, 1'b1);
    tick;
    drv(1'b0, 32'h0, 6'h0, '0);
    @(negedge clk);
    chk("one_pp_valid", out_valid, 1'b1);
    chk("one_pp_tag", out_tag, 5'd3);
    chk("one_pp_ready", in_ready, 1'b1);
    tick;
    @(negedge clk);
    chk("drain_valid", out_valid, 1'b0);
    chk("drain_hold_tag", out_tag, 5'd3);

    // flush with a full buffer and a pending input
    out_ready = 1'b0;
    drv(1'b1, iw(5'd4), C_I, 5'd4);
    tick;
    drv(1'b1, iw(5'd5), C_I, 5'd5);
    tick;
    drv(1'b1, iw(5'd7), C_I, 5'd7);
    flush = 1'b1;
    @(negedge clk);
    chk("fl_pre_valid", out_valid, 1'b1);
    chk("fl_pre_ready", in_ready, 1'b0);
    tick;
    flush = 1'b0;
    drv(1'b0, 32'h0, 6'h0, '0);
    @(negedge clk);
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_ready", in_ready, 1'b1);
    chk("fl_hold_tag", out_tag, 5'd4);
    drv(1'b1, iw(5'd6), C_I, 5'd6);
    tick;
    drv(1'b1, iw(5'd7), C_I, 5'd7);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    drv(1'b0, 32'h0, 6'h0, '0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("fl_drop%0d", i), out_valid, 1'b0);
      tick;
    end

    // reset in the middle of traffic
    out_ready = 1'b0;
    drv(1'b1, iw(5'd8), C_I, 5'd8);
    tick;
    drv(1'b1, 32'hFFF00093, 6'b000011, 5'd9);
    tick;
    drv(1'b1, iw(5'd10), C_I, 5'd10);
    rstn = 1'b0;
    tick;
    @(negedge clk);
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_imm", imm, 32'h0);
    chk("mrst_tag", out_tag, 5'h0);
    chk("mrst_err", imm_err, 1'b0);
    rstn = 1'b1;
    drv(1'b0, 32'h0, 6'h0, '0);
    tick;

    last = '{32'h0, '0, 1'b0};
    for (int k = 0; k < 600; k++) begin
      logic [5:0]  c;
      logic [32:0] r;
      ent_t        e;
      bit          pu;
      bit          po;
      c = ($urandom % 8 == 0) ? 6'($urandom)
                              : 6'(1 << ($urandom % 6));
      drv($urandom % 4 != 0, $urandom, c, TW'($urandom));
      out_ready = ($urandom % 3 != 0);
      flush     = ($urandom % 20 == 0);
      @(negedge clk);
      e = (q.size() != 0) ? q[0] : last;
      chk("rnd_valid", out_valid, q.size() != 0);
      chk("rnd_ready", in_ready, q.size() < 2);
      chk("rnd_imm", imm, e.imm);
      chk("rnd_tag", out_tag, e.tag);
      chk("rnd_err", imm_err, e.err);
      last = e;
      if (flush) begin
        q.delete();
      end else begin
        pu = in_valid && q.size() < 2;
        po = q.size() != 0 && out_ready;
        if (po) void'(q.pop_front());
        if (pu) begin
          r = ref_imm(instr, c);
          q.push_back('{r[31:0], in_tag, r[32]});
        end
      end
      tick;
    end
    flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
